// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// State encoding and counter-width helper used by serial_add_sub.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r_bits;
        int v;
        r_bits = 0;
        v = value - 1;
        while (v > 0) begin
            r_bits++;
            v = v >>> 1;
        end
        return r_bits;
    endfunction

endpackage

// File: rtl/serial_add_sub_fa_cell.sv
// One-bit full adder, purely combinational.
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, valid/ready on both sides.
// Optional signed-overflow output enabled by SERIAL_ADD_SUB_OVF_EN.
//
// state | meaning
// IDLE  | ready for operands
// SHIFT | one bit per cycle, then one settle cycle before DONE
// DONE  | result presented until out_ready
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADD_SUB_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             w_sum;
    logic             w_carry;
    logic             w_accept;
    logic             w_shift_en;

    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_shift_en = (r_state == S_SHIFT) && (r_count != CNT_END);

    fa_cell u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_sum),
        .o_cout (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter runs one step past the last bit so DONE lands at accept+WIDTH+1.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)             w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_count == CNT_END)   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)            w_state_nxt = S_IDLE;
            default:                           w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b ^ {WIDTH{control}};
            r_carry  <= control;
            r_count  <= '0;
        end else if (w_shift_en) begin
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_carry  <= w_carry;
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_count  <= r_count + CW'(1);
        end
    end

`ifdef SERIAL_ADD_SUB_OVF_EN
    logic r_ovf;

    // Carry into vs. out of the MSB cell gives two's-complement overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_shift_en && (r_count == CNT_LAST)) begin
            r_ovf <= r_carry ^ w_carry;
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign cout      = r_carry;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub with an arithmetic reference model.
module tb_serial_add_sub;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic         ovf;
`endif

    int   total;
    int   bad;
    exp_t sb[$];

    serial_add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADD_SUB_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned wrap, borrow as a>=b, signed range test.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ctl);
        exp_t e;
        int   ia, ib, s, sa, sb_s, ideal;
        ia = int'(av);
        ib = int'(bv);
        sa   = (ia >= (1 << (W-1))) ? ia - (1 << W) : ia;
        sb_s = (ib >= (1 << (W-1))) ? ib - (1 << W) : ib;
        if (!ctl) begin
            s     = ia + ib;
            e.c   = (s >= (1 << W));
            ideal = sa + sb_s;
        end else begin
            s     = ia - ib + (1 << W);
            e.c   = (ia >= ib);
            ideal = sa - sb_s;
        end
        e.r = W'(s % (1 << W));
        e.o = (ideal > (1 << (W-1)) - 1) || (ideal < -(1 << (W-1)));
        return e;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'(result), 32'(e.r));
                    chk("cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADD_SUB_OVF_EN
                    chk("ovf", 32'(ovf), 32'(e.o));
`endif
                end
            end
        end
    end

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ctl, input int bp);
        int   n;
        exp_t e;
        @(posedge clk); #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 32'(n < 100), 1);
        e = model(av, bv, ctl);
        sb.push_back(e);
        out_ready = (bp == 0);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        control   = ctl;
        @(posedge clk); #1;
        n = 0;
        // Garbage operands with random in_valid while busy must be ignored.
        while (!out_valid && n < 50) begin
            chk("in_ready_busy", 32'(in_ready), 0);
            chk("busy", 32'(busy), 1);
            in_valid = 1'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            control  = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(n), 32'(W + 1));
        for (int i = 0; i < bp; i++) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_result", 32'(result), 32'(e.r));
            chk("hold_cout", 32'(cout), 32'(e.c));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_clear", 32'(out_valid), 0);
        chk("idle_in_ready", 32'(in_ready), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        control   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(4'd3,  4'd5, 1'b0, 0);
        do_op(4'd9,  4'd4, 1'b1, 0);
        do_op(4'd2,  4'd5, 1'b1, 0);
        do_op(4'd15, 4'd1, 1'b0, 0);
        do_op(4'd7,  4'd1, 1'b0, 0);
        do_op(4'd8,  4'd1, 1'b1, 0);
        do_op(4'd10, 4'd3, 1'b0, 10);

        // Asynchronous reset two bits into a shift.
        @(posedge clk); #1;
        in_valid = 1'b1;
        a        = 4'd5;
        b        = 4'd3;
        control  = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_result", 32'(result), 0);
        chk("mid_rst_cout", 32'(cout), 0);
        chk("mid_rst_busy", 32'(busy), 0);
`ifdef SERIAL_ADD_SUB_OVF_EN
        chk("mid_rst_ovf", 32'(ovf), 0);
`endif
        #1;
        rst_n = 1'b1;
        do_op(4'd6, 4'd6, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
